// File: rtl/in_pi_rx_if.sv
// Bundle between the Raspberry Pi GPIO pins and the in_pi_rx receiver.
//   master : the Pi side (drives pi_clk / pi_dat, observes the results)
//   slave  : the receiver (samples pi_clk / pi_dat, drives the results)
// Signals:
//   pi_clk, pi_dat : raw, asynchronous, bouncy serial lines from the Pi
//   data_out[7:0]  : last received byte
//   data_valid     : 1-cycle strobe, data_out updated on the same cycle
//   pi_ack         : long stable high level returned to the Pi after each byte
//   frame_err      : 1-cycle strobe, frame aborted by timeout
//   overrun        : 1-cycle strobe, pi_clk rise accepted while pi_ack high
interface in_pi_rx_if;
  logic       pi_clk;
  logic       pi_dat;
  logic [7:0] data_out;
  logic       data_valid;
  logic       pi_ack;
  logic       frame_err;
  logic       overrun;

  modport master (
    output pi_clk, pi_dat,
    input  data_out, data_valid, pi_ack, frame_err, overrun
  );

  modport slave (
    input  pi_clk, pi_dat,
    output data_out, data_valid, pi_ack, frame_err, overrun
  );
endinterface

// File: rtl/in_pi_rx.sv
// Serial byte receiver for the Raspberry Pi link (pi_clk + pi_dat over jumper wires).
// Both lines are 2-FF synchronised and debounced; each accepted rise of the
// debounced clock shifts in one bit, MSB first. After 8 bits the byte is
// presented with a 1-cycle data_valid strobe and pi_ack is held high for
// ACK_CYCLES cycles so the Pi can poll it.
// Ports:
//   clk   : internal 100 MHz clock
//   rst_n : asynchronous active-low reset
//   bus   : in_pi_rx_if.slave (pi_clk, pi_dat in; data_out, data_valid,
//           pi_ack, frame_err, overrun out)
module in_pi_rx #(
  parameter int unsigned DEB_CYCLES     = 8191,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned ACK_CYCLES     = 8191
) (
  input  logic       clk,
  input  logic       rst_n,
  in_pi_rx_if.slave  bus
);

  localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned ACK_W = $clog2(ACK_CYCLES + 1);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, ACK} state_e;

  // Line index 0 = pi_clk, 1 = pi_dat
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       stable_q, stable_d;
  logic [DEB_W-1:0] deb_cnt_q [2];
  logic [DEB_W-1:0] deb_cnt_d [2];
  logic             clk_prev_q, clk_prev_d;

  state_e           state_q, state_d;
  logic [6:0]       shreg_q, shreg_d;   // only 7 bits kept; the 8th goes straight to data_out
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [ACK_W-1:0] ack_cnt_q, ack_cnt_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             pi_ack_q, pi_ack_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;

  logic             rise;
  logic             dat;

  // Debounce: a line must differ from its stable level for DEB_CYCLES
  // consecutive cycles; any return to the stable level restarts the count.
  always_comb begin
    stable_d = stable_q;
    for (int unsigned i = 0; i < 2; i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
        end
      end
    end
  end

  assign rise       = stable_q[0] & ~clk_prev_q;
  assign dat        = stable_q[1];
  assign clk_prev_d = stable_q[0];

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    tmo_d        = tmo_q;
    ack_cnt_d    = ack_cnt_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    pi_ack_d     = pi_ack_q;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rise) begin
          shreg_d   = {shreg_q[5:0], dat};
          bit_cnt_d = 4'd1;
          tmo_d     = '0;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        // A rise on the timeout cycle takes priority over the abort.
        if (rise) begin
          tmo_d = '0;
          if (bit_cnt_q == 4'd7) begin
            data_out_d   = {shreg_q, dat};
            data_valid_d = 1'b1;
            pi_ack_d     = 1'b1;
            ack_cnt_d    = '0;
            bit_cnt_d    = 4'd8;
            shreg_d      = '0;
            state_d      = ACK;
          end else begin
            shreg_d   = {shreg_q[5:0], dat};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else if (tmo_q == TMO_LAST) begin
          frame_err_d = 1'b1;
          shreg_d     = '0;
          bit_cnt_d   = '0;
          tmo_d       = '0;
          state_d     = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      ACK: begin
        if (rise) begin
          overrun_d = 1'b1;
        end
        if (ack_cnt_q == ACK_LAST) begin
          pi_ack_d  = 1'b0;
          ack_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          ack_cnt_d = ack_cnt_q + ACK_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      deb_cnt_q[0] <= '0;
      deb_cnt_q[1] <= '0;
      clk_prev_q   <= 1'b0;
      state_q      <= IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      tmo_q        <= '0;
      ack_cnt_q    <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      pi_ack_q     <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync1_q      <= {bus.pi_dat, bus.pi_clk};
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      deb_cnt_q[0] <= deb_cnt_d[0];
      deb_cnt_q[1] <= deb_cnt_d[1];
      clk_prev_q   <= clk_prev_d;
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      tmo_q        <= tmo_d;
      ack_cnt_q    <= ack_cnt_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      pi_ack_q     <= pi_ack_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.pi_ack     = pi_ack_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_in_pi_rx.sv
// Directed bench for in_pi_rx. Instance A uses 16/2000/16; instance B uses a
// 64-cycle ack so a second debounced pi_clk rise can land inside pi_ack.
module tb_in_pi_rx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pc = 1'b0;
  logic pd = 1'b0;
  logic sel = 1'b0;   // 0: pins go to A, 1: pins go to B

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_rise = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  in_pi_rx_if bus_a ();
  in_pi_rx_if bus_b ();

  assign bus_a.pi_clk = sel ? 1'b0 : pc;
  assign bus_a.pi_dat = sel ? 1'b0 : pd;
  assign bus_b.pi_clk = sel ? pc : 1'b0;
  assign bus_b.pi_dat = sel ? pd : 1'b0;

  in_pi_rx #(.DEB_CYCLES(16), .TIMEOUT_CYCLES(2000), .ACK_CYCLES(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a));
  in_pi_rx #(.DEB_CYCLES(16), .TIMEOUT_CYCLES(2000), .ACK_CYCLES(64)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b));

  // Output monitors
  int va_cnt = 0, va_run = 0, va_max = 0, aa_run = 0, aa_len = 0;
  int fe_cnt = 0, fe_cyc = 0, ov_a = 0;
  logic [7:0] va_last = '0, va_prev = '0;
  int vb_cnt = 0, ab_run = 0, ab_len = 0, ov_b = 0;
  logic [7:0] vb_last = '0;

  always @(negedge clk) begin
    if (bus_a.data_valid) begin
      va_cnt++; va_prev = va_last; va_last = bus_a.data_out; va_run++;
      if (va_run > va_max) va_max = va_run;
    end else va_run = 0;
    if (bus_a.pi_ack) aa_run++;
    else if (aa_run != 0) begin aa_len = aa_run; aa_run = 0; end
    if (bus_a.frame_err) begin fe_cnt++; fe_cyc = cyc; end
    if (bus_a.overrun) ov_a++;
    if (bus_b.data_valid) begin vb_cnt++; vb_last = bus_b.data_out; end
    if (bus_b.pi_ack) ab_run++;
    else if (ab_run != 0) begin ab_len = ab_run; ab_run = 0; end
    if (bus_b.overrun) ov_b++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    wait_cyc(1);
    pd = b;
    wait_cyc(100);
    pc = 1'b1;
    t_rise = cyc;
    wait_cyc(100);
    pc = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  initial begin
    logic [7:0] v;
    // Reset state
    wait_cyc(3);
    chk("rst_data_out", bus_a.data_out, 8'h00);
    chk("rst_outs", {bus_a.data_valid, bus_a.pi_ack, bus_a.frame_err, bus_a.overrun}, 4'b0000);
    rst_n = 1'b1;
    wait_cyc(5);

    // Basic byte
    send_byte(8'hA5);
    wait_cyc(50);
    chk("a5_value", va_last, 8'hA5);
    chk("a5_valid_cnt", va_cnt, 1);
    chk("a5_valid_width", va_max, 1);
    chk("a5_ack_len", aa_len, 16);
    chk("a5_data_held", bus_a.data_out, 8'hA5);

    // 10-cycle pi_clk glitch after 3 bits of 0x3C
    v = 8'h3C;
    for (int i = 7; i >= 5; i--) send_bit(v[i]);
    wait_cyc(50);
    pc = 1'b1;
    wait_cyc(10);
    pc = 1'b0;
    wait_cyc(100);
    for (int i = 4; i >= 0; i--) send_bit(v[i]);
    wait_cyc(50);
    chk("glitch_value", va_last, 8'h3C);
    chk("glitch_valid_cnt", va_cnt, 2);

    // Three bits then silence -> timeout
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    wait_cyc(2200);
    chk("tmo_frame_err_cnt", fe_cnt, 1);
    chk("tmo_frame_err_delay", fe_cyc - t_rise, 2019);
    chk("tmo_no_valid", va_cnt, 2);
    chk("tmo_data_kept", bus_a.data_out, 8'h3C);
    send_byte(8'h81);
    wait_cyc(50);
    chk("after_tmo_value", va_last, 8'h81);
    chk("after_tmo_valid_cnt", va_cnt, 3);

    // Reset in the middle of a frame
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    wait_cyc(1);
    rst_n = 1'b0;
    #1;
    chk("midrst_data_out", bus_a.data_out, 8'h00);
    chk("midrst_outs", {bus_a.data_valid, bus_a.pi_ack, bus_a.frame_err, bus_a.overrun}, 4'b0000);
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(5);
    send_byte(8'hFF);
    wait_cyc(50);
    chk("after_rst_value", bus_a.data_out, 8'hFF);
    chk("after_rst_valid_cnt", va_cnt, 4);
    chk("after_rst_no_frame_err", fe_cnt, 1);

    // Back-to-back bytes
    send_byte(8'h00);
    send_byte(8'hFF);
    wait_cyc(50);
    chk("b2b_valid_cnt", va_cnt, 6);
    chk("b2b_first", va_prev, 8'h00);
    chk("b2b_second", va_last, 8'hFF);
    chk("b2b_ack_len", aa_len, 16);
    chk("a_no_overrun", ov_a, 0);

    // Overrun on instance B: second rise lands inside the 64-cycle ack
    sel = 1'b1;
    wait_cyc(5);
    v = 8'h5A;
    for (int i = 7; i >= 1; i--) send_bit(v[i]);
    wait_cyc(1);
    pd = v[0];
    wait_cyc(100);
    pc = 1'b1;
    wait_cyc(20);
    pc = 1'b0;
    wait_cyc(20);
    pc = 1'b1;
    wait_cyc(20);
    pc = 1'b0;
    wait_cyc(200);
    chk("ovr_count", ov_b, 1);
    chk("ovr_ack_len", ab_len, 64);
    chk("ovr_valid_cnt", vb_cnt, 1);
    chk("ovr_value", vb_last, 8'h5A);
    chk("ovr_data_held", bus_b.data_out, 8'h5A);
    chk("ovr_a_idle", va_cnt, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
